// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the write-back / register-file slice.
// Contents: datapath width, register-address width, the hard-wired zero register,
// retired-instruction counter width, and the write-port request struct that
// connects the write-back wrapper to the storage array.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam int CNT_W      = 64;

    // One register-file write request, already qualified by the wrapper.
    typedef struct packed {
        logic                  en;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wbReq_t;

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: architectural register storage, 2 combinational reads, 1 write.
// Ports:
//   clk, reset        rising-edge clock, async active-high reset (clears every entry)
//   wrReq             qualified write request (en/addr/data), committed on posedge clk
//   readAddr1/2       read addresses
//   readData1/2       raw stored values (no bypass, no x0 masking beyond storage)
// Entry 0 is never written so it stays at its reset value of zero.
module regfile_2r1w
    import riscv_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  wbReq_t                wrReq,
    input  logic [REG_ADDR_W-1:0] readAddr1,
    input  logic [REG_ADDR_W-1:0] readAddr2,
    output logic [XLEN-1:0]       readData1,
    output logic [XLEN-1:0]       readData2
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wrReq.en && wrReq.addr != REG_ZERO) begin
            regs[wrReq.addr] <= wrReq.data;
        end
    end

    assign readData1 = regs[readAddr1];
    assign readData2 = regs[readAddr2];

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage plus architectural register file.
// Selects the write-back value, commits it to x1..x31, serves two decode read
// ports with same-cycle write-through bypass, drives the WB forwarding bus and
// keeps a retired-instruction counter.
// Ports:
//   clk, reset                    clock, async active-high reset
//   stall                         WB hold: no commit, no count
//   instrValidIn                  MEM/WB slot holds a real instruction
//   memToRegIn, regWriteIn        write-back source select / rd write request
//   dataMemoryIn, aluIn           load data / ALU result
//   regWriteAdressIn              rd
//   readAddr1/2, readData1/2      decode read ports (combinational, bypassed)
//   wbData, wbAddr, wbEnable      forwarding bus (combinational)
//   instretOut                    retired-instruction count (registered)
module wb_regfile
    import riscv_pkg::*;
#(
    parameter int NREGS   = 32,
    parameter int CNTW    = CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  instrValidIn,
    input  logic                  memToRegIn,
    input  logic                  regWriteIn,
    input  logic [XLEN-1:0]       dataMemoryIn,
    input  logic [XLEN-1:0]       aluIn,
    input  logic [REG_ADDR_W-1:0] regWriteAdressIn,
    input  logic [REG_ADDR_W-1:0] readAddr1,
    input  logic [REG_ADDR_W-1:0] readAddr2,
    output logic [XLEN-1:0]       readData1,
    output logic [XLEN-1:0]       readData2,
    output logic [XLEN-1:0]       wbData,
    output logic [REG_ADDR_W-1:0] wbAddr,
    output logic                  wbEnable,
    output logic [CNTW-1:0]       instretOut
);

    wbReq_t          wrReq;
    logic [XLEN-1:0] rfData1;
    logic [XLEN-1:0] rfData2;
    logic            retire;

    assign wbData = memToRegIn ? dataMemoryIn : aluIn;
    assign wbAddr = regWriteAdressIn;

    // Reset is folded in so nothing downstream forwards a write that the
    // storage array will never see.
    assign wbEnable = regWriteIn & instrValidIn & ~stall & ~reset
                      & (regWriteAdressIn != REG_ZERO);

    assign wrReq = '{en: wbEnable, addr: wbAddr, data: wbData};

    regfile_2r1w #(.NREGS(NREGS)) uRegfile (
        .clk       (clk),
        .reset     (reset),
        .wrReq     (wrReq),
        .readAddr1 (readAddr1),
        .readAddr2 (readAddr2),
        .readData1 (rfData1),
        .readData2 (rfData2)
    );

    // x0 masking wins over bypass; wbEnable already excludes rd == x0, the
    // explicit check keeps the read path independent of that qualification.
    always_comb begin
        readData1 = rfData1;
        if (readAddr1 == REG_ZERO)
            readData1 = '0;
        else if (wbEnable && readAddr1 == wbAddr)
            readData1 = wbData;
    end

    always_comb begin
        readData2 = rfData2;
        if (readAddr2 == REG_ZERO)
            readData2 = '0;
        else if (wbEnable && readAddr2 == wbAddr)
            readData2 = wbData;
    end

    // Stalls hold MEM/WB upstream, so counting only on non-stalled valid
    // cycles retires each instruction exactly once. Stores/branches count too.
    assign retire = instrValidIn & ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            instretOut <= '0;
        else if (retire)
            instretOut <= instretOut + 1'b1;
    end

endmodule
